// File: rtl/imm_ext_if.sv
// Handshake bundle for the immediate-extension pipe: upstream request side
// (in_*) and downstream result side (out_*).
interface imm_ext_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  // The block itself: consumes requests, produces results.
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  // The environment around the block: decode upstream and ALU mux downstream.
  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined MIPS32 immediate extender (sign / zero / LUI / branch-offset)
// with an output register plus one skid entry behind a valid/ready handshake.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  imm_ext_if.slave   bus
);

  localparam logic [1:0] MODE_SIGN = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_LUI  = 2'b10;
  localparam logic [1:0] MODE_BR   = 2'b11;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state,    state_nxt;
  logic [OUT_W-1:0] or_data,  or_data_nxt;
  logic [TAG_W-1:0] or_tag,   or_tag_nxt;
  logic [OUT_W-1:0] sk_data,  sk_data_nxt;
  logic [TAG_W-1:0] sk_tag,   sk_tag_nxt;
  logic             ready_q;
  logic [OUT_W-1:0] ext;
  logic             accept;
  logic             deliver;

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = or_data;
  assign bus.out_tag   = or_tag;

  assign accept  = bus.in_valid & ready_q;
  assign deliver = bus.out_valid & bus.out_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ext = '0;
    unique case (bus.in_mode)
      MODE_SIGN: ext = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
      MODE_ZERO: ext = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
      MODE_LUI:  ext = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BR:   ext = {{(OUT_W-IN_W-2){bus.in_imm[IN_W-1]}}, bus.in_imm, 2'b00};
      default:   ext = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    or_data_nxt = or_data;
    or_tag_nxt  = or_tag;
    sk_data_nxt = sk_data;
    sk_tag_nxt  = sk_tag;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt   = ONE;
          or_data_nxt = ext;
          or_tag_nxt  = bus.in_tag;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          or_data_nxt = ext;
          or_tag_nxt  = bus.in_tag;
        end else if (accept) begin
          // Output is stalled: park the newcomer behind it.
          state_nxt   = TWO;
          sk_data_nxt = ext;
          sk_tag_nxt  = bus.in_tag;
        end else if (deliver) begin
          state_nxt   = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          state_nxt   = ONE;
          or_data_nxt = sk_data;
          or_tag_nxt  = sk_tag;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the data/tag registers are reset too, since the output bus and the
  // skid entry must read zero after reset rather than stale contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      or_data <= '0;
      or_tag  <= '0;
      sk_data <= '0;
      sk_tag  <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      or_data <= or_data_nxt;
      or_tag  <= or_tag_nxt;
      sk_data <= sk_data_nxt;
      sk_tag  <= sk_tag_nxt;
      // Registered ready: open whenever the skid entry will be free next cycle.
      ready_q <= (state_nxt != TWO);
    end
  end

endmodule
